// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller that sits beside the decode stage.
// It selects forwarded operands for rs1/rs2 and detects load-use hazards.
// A scoreboard tracks long-latency writebacks. A redirect flush is deferred
// while memory stalls the pipe. A saturating counter records stalled cycles.
module hazard_ctrl #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NFWD = 3,
    parameter int CNTW = 32,
    localparam int RW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [RW-1:0]        id_rs1,
    input  logic [RW-1:0]        id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 ex_memread,
    input  logic                 ex_regwrite,
    input  logic [RW-1:0]        ex_dst,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*RW-1:0]   fwd_dst,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 issue_long,
    input  logic [RW-1:0]        issue_dst,
    input  logic                 long_done,
    input  logic [RW-1:0]        long_dst,
    input  logic                 mem_stall,
    input  logic                 redirect,
    output logic                 srca_mux,
    output logic [XLEN-1:0]      srca_fwd,
    output logic                 srcb_mux,
    output logic [XLEN-1:0]      srcb_fwd,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 flush_ifid,
    output logic [CNTW-1:0]      stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NREG-1:0] sb_q, sb_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            a_match, b_match;
    logic [XLEN-1:0] a_data, b_data;
    logic            rs1_live, rs2_live;
    logic            rs1_busy, rs2_busy;
    logic            sb_hit;
    logic            load_use;
    logic            stall_raw;
    logic            flush_raw;

    // A source operand only matters when decode reads it and it is not x0.
    always_comb begin
        rs1_live = id_use_rs1 && (id_rs1 != '0);
        rs2_live = id_use_rs2 && (id_rs2 != '0);
    end

    // Search all forwarding sources; scanning from the oldest down lets the youngest match win.
    always_comb begin
        a_match = 1'b0;
        a_data  = '0;
        b_match = 1'b0;
        b_data  = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_dst[i*RW +: RW] == id_rs1)) begin
                a_match = 1'b1;
                a_data  = fwd_data[i*XLEN +: XLEN];
            end
            if (fwd_valid[i] && (fwd_dst[i*RW +: RW] == id_rs2)) begin
                b_match = 1'b1;
                b_data  = fwd_data[i*XLEN +: XLEN];
            end
        end
    end

    // A live operand whose register awaits a long-latency result must wait, not forward.
    always_comb begin
        rs1_busy = rs1_live && sb_q[id_rs1];
        rs2_busy = rs2_live && sb_q[id_rs2];
        sb_hit   = rs1_busy || rs2_busy;
    end

    // A load in EX cannot forward in time, so a dependent decode instruction waits one cycle.
    always_comb begin
        load_use = ex_memread && ex_regwrite && (ex_dst != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_dst)) ||
                    (id_use_rs2 && (id_rs2 == ex_dst)));
        stall_raw = load_use || sb_hit || mem_stall;
    end

    // Scoreboard update: completion clears first so that a same-cycle issue re-sets the bit.
    always_comb begin
        sb_d = sb_q;
        if (long_done) begin
            sb_d[long_dst] = 1'b0;
        end
        if (issue_long && (issue_dst != '0)) begin
            sb_d[issue_dst] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // Redirect FSM: a flush requested under a memory stall is held until the pipe moves.
    always_comb begin
        state_d   = state_q;
        flush_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    if (mem_stall) begin
                        state_d = HOLD;
                    end else begin
                        flush_raw = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!mem_stall) begin
                    flush_raw = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are forced quiet while reset is asserted; a flush lets IF advance to the new target.
    always_comb begin
        srca_mux   = resetn && a_match && rs1_live && !rs1_busy;
        srcb_mux   = resetn && b_match && rs2_live && !rs2_busy;
        srca_fwd   = srca_mux ? a_data : '0;
        srcb_fwd   = srcb_mux ? b_data : '0;
        flush_ifid = resetn && flush_raw;
        stall_id   = resetn && stall_raw;
        stall_if   = stall_id && !flush_ifid;
    end

    // Count stalled decode cycles, sticking at the maximum value.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_id && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with hand-computed expectations for hazard_ctrl.
module tb_hazard_ctrl;

    localparam int XLEN = 64;
    localparam int RW   = 5;
    localparam int CNTW = 4;

    localparam logic [63:0] D0 = 64'hAAAA_0000_1111_0000;
    localparam logic [63:0] D1 = 64'hBBBB_0000_2222_0001;
    localparam logic [63:0] D2 = 64'hCCCC_0000_3333_0002;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic        memrd;
        logic        regwr;
        logic [4:0]  exd;
        logic [2:0]  fv;
        logic [4:0]  fd0;
        logic [4:0]  fd1;
        logic [4:0]  fd2;
        logic        il;
        logic [4:0]  idst;
        logic        ldone;
        logic [4:0]  ldst;
        logic        ms;
        logic        rd;
        logic        amux;
        logic [63:0] afwd;
        logic        bmux;
        logic [63:0] bfwd;
        logic        sif;
        logic        sid;
        logic        fl;
        logic        skipfwd;
    } vec_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic [RW-1:0]     id_rs1, id_rs2, ex_dst, issue_dst, long_dst;
    logic              id_use_rs1, id_use_rs2, ex_memread, ex_regwrite;
    logic [2:0]        fwd_valid;
    logic [3*RW-1:0]   fwd_dst;
    logic [3*XLEN-1:0] fwd_data;
    logic              issue_long, long_done, mem_stall, redirect;
    logic              srca_mux, srcb_mux, stall_if, stall_id, flush_ifid;
    logic [XLEN-1:0]   srca_fwd, srcb_fwd;
    logic [CNTW-1:0]   stall_cnt;

    int              tests = 0;
    int              fails = 0;
    logic [CNTW-1:0] cnt_model = '0;
    vec_t            tbl[12];
    vec_t            zero_v;

    hazard_ctrl #(.XLEN(XLEN), .NREG(32), .NFWD(3), .CNTW(CNTW)) dut (
        .clk(clk), .resetn(resetn),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_dst(ex_dst),
        .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
        .issue_long(issue_long), .issue_dst(issue_dst),
        .long_done(long_done), .long_dst(long_dst),
        .mem_stall(mem_stall), .redirect(redirect),
        .srca_mux(srca_mux), .srca_fwd(srca_fwd),
        .srcb_mux(srcb_mux), .srcb_fwd(srcb_fwd),
        .stall_if(stall_if), .stall_id(stall_id),
        .flush_ifid(flush_ifid), .stall_cnt(stall_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input string sig,
                         input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s.%s: got %h expected %h", tag, sig, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_use_rs1  = v.use1;
        id_use_rs2  = v.use2;
        ex_memread  = v.memrd;
        ex_regwrite = v.regwr;
        ex_dst      = v.exd;
        fwd_valid   = v.fv;
        fwd_dst     = {v.fd2, v.fd1, v.fd0};
        fwd_data    = {D2, D1, D0};
        issue_long  = v.il;
        issue_dst   = v.idst;
        long_done   = v.ldone;
        long_dst    = v.ldst;
        mem_stall   = v.ms;
        redirect    = v.rd;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        check(tag, "srca_mux", {63'd0, srca_mux}, {63'd0, v.amux});
        check(tag, "srcb_mux", {63'd0, srcb_mux}, {63'd0, v.bmux});
        if (!v.skipfwd) begin
            check(tag, "srca_fwd", srca_fwd, v.afwd);
            check(tag, "srcb_fwd", srcb_fwd, v.bfwd);
        end
        check(tag, "stall_if", {63'd0, stall_if}, {63'd0, v.sif});
        check(tag, "stall_id", {63'd0, stall_id}, {63'd0, v.sid});
        check(tag, "flush_ifid", {63'd0, flush_ifid}, {63'd0, v.fl});
        check(tag, "stall_cnt", {60'd0, stall_cnt}, {60'd0, cnt_model});
    endtask

    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, tag);
        if (v.sid && (cnt_model != 4'hF)) cnt_model = cnt_model + 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        zero_v = '{default: 0};

        tbl[0]  = '{rs1: 3, use1: 1, default: 0};
        tbl[1]  = '{rs1: 5, use1: 1, rs2: 3, use2: 1, fv: 3'b101, fd0: 5, fd2: 5,
                    amux: 1, afwd: D0, default: 0};
        tbl[2]  = '{rs1: 0, use1: 1, rs2: 0, use2: 1, fv: 3'b111, default: 0};
        tbl[3]  = '{rs1: 5, use1: 1, rs2: 6, use2: 1, fv: 3'b110, fd0: 5, fd1: 6, fd2: 5,
                    amux: 1, afwd: D2, bmux: 1, bfwd: D1, default: 0};
        tbl[4]  = '{rs1: 5, use1: 0, fv: 3'b001, fd0: 5, default: 0};
        tbl[5]  = '{memrd: 1, regwr: 1, exd: 7, rs1: 7, use1: 1, sid: 1, sif: 1, default: 0};
        tbl[6]  = '{memrd: 1, regwr: 0, exd: 7, rs1: 7, use1: 1, default: 0};
        tbl[7]  = '{memrd: 1, regwr: 1, exd: 0, rs1: 0, use1: 1, default: 0};
        tbl[8]  = '{memrd: 1, regwr: 1, exd: 7, rs1: 3, use1: 1, rs2: 7, use2: 0, default: 0};
        tbl[9]  = '{ms: 1, sid: 1, sif: 1, default: 0};
        tbl[10] = '{rd: 1, fl: 1, default: 0};
        tbl[11] = '{rd: 1, memrd: 1, regwr: 1, exd: 7, rs2: 7, use2: 1,
                    sid: 1, sif: 0, fl: 1, default: 0};

        // Reset with busy inputs: outputs must stay quiet, nothing may be latched.
        resetn = 1'b0;
        applyStimulus('{rs1: 5, use1: 1, fv: 3'b001, fd0: 5, ms: 1, rd: 1,
                        il: 1, idst: 3, memrd: 1, regwr: 1, exd: 5, default: 0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput(zero_v, "reset");
        resetn = 1'b1;
        applyStimulus(zero_v);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            runVector(tbl[i], $sformatf("vec%0d", i));
        end

        // Long-latency op on x9: forward before the bit lands, stall until done, then resume.
        runVector('{il: 1, idst: 9, rs2: 9, use2: 1, fv: 3'b001, fd0: 9,
                    bmux: 1, bfwd: D0, default: 0}, "sb_issue");
        for (int i = 0; i < 3; i++) begin
            runVector('{rs2: 9, use2: 1, fv: 3'b001, fd0: 9, sid: 1, sif: 1,
                        skipfwd: 1, default: 0}, $sformatf("sb_wait%0d", i));
        end
        runVector('{ldone: 1, ldst: 9, rs2: 9, use2: 1, fv: 3'b001, fd0: 9,
                    sid: 1, sif: 1, skipfwd: 1, default: 0}, "sb_done");
        runVector('{rs2: 9, use2: 1, fv: 3'b001, fd0: 9, bmux: 1, bfwd: D0,
                    default: 0}, "sb_free");

        // Same register issued and completed in one cycle: the issue wins.
        runVector('{il: 1, idst: 10, ldone: 1, ldst: 10, default: 0}, "sb_setclr");
        runVector('{rs1: 10, use1: 1, sid: 1, sif: 1, default: 0}, "sb_setwins");
        runVector('{ldone: 1, ldst: 10, rs1: 10, use1: 1, sid: 1, sif: 1, default: 0},
                  "sb_clr10");
        runVector('{rs1: 10, use1: 1, default: 0}, "sb_free10");

        // Redirect under a memory stall: one deferred flush, extra redirect absorbed.
        runVector('{rd: 1, ms: 1, sid: 1, sif: 1, default: 0}, "hold1");
        runVector('{rd: 1, ms: 1, sid: 1, sif: 1, default: 0}, "hold2");
        runVector('{ms: 1, sid: 1, sif: 1, default: 0}, "hold3");
        runVector('{fl: 1, default: 0}, "hold_release");
        runVector(zero_v, "hold_single");

        // Leave a scoreboard bit set, then saturate the counter.
        runVector('{il: 1, idst: 12, default: 0}, "sb_set12");
        for (int i = 0; i < 20; i++) begin
            runVector('{ms: 1, sid: 1, sif: 1, default: 0}, $sformatf("sat%0d", i));
        end
        @(negedge clk);
        check("saturate", "stall_cnt", {60'd0, stall_cnt}, 64'd15);

        // One reset edge clears the counter and the scoreboard.
        resetn = 1'b0;
        applyStimulus(zero_v);
        @(posedge clk);
        @(negedge clk);
        check("reset2", "stall_cnt", {60'd0, stall_cnt}, 64'd0);
        cnt_model = '0;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        runVector('{rs1: 12, use1: 1, default: 0}, "sb_cleared");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
